// File: rtl/mul_arbiter_if.sv
// Bundle of signals between the requesters, the shared mul1616 multiplier
// and the arbiter that sequences them.
interface mul_arbiter_if;
  // Requester side
  logic [1:0]  req_valid;
  logic [15:0] req_a0;
  logic [15:0] req_b0;
  logic [15:0] req_a1;
  logic [15:0] req_b1;
  logic [1:0]  req_ack;
  logic        resp_valid;
  logic        resp_id;
  logic [31:0] resp_product;
  logic        resp_err;
  logic        busy;

  // Multiplier side
  logic        mul_ready;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic        mul_reset;
  logic        mul_done;
  logic [31:0] mul_product;

  // Arbiter view
  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, mul_done, mul_product,
    output req_ack, resp_valid, resp_id, resp_product, resp_err, busy,
           mul_ready, mul_a, mul_b, mul_reset
  );

  // Environment view (requesters plus multiplier)
  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, mul_done, mul_product,
    input  req_ack, resp_valid, resp_id, resp_product, resp_err, busy,
           mul_ready, mul_a, mul_b, mul_reset
  );
endinterface

// File: rtl/mul_arbiter.sv
// Shares one 16x16 signed multiplier between two requesters (0 = EIS MUL,
// 1 = ASH scaling). Round-robin on contention, holds operands while the
// multiplier runs, returns the product to the owner, and aborts a hung
// multiplier after TIMEOUT cycles with an error response.
module mul_arbiter #(
  parameter int unsigned TIMEOUT = 40  // must be >= 20 to cover the 18-cycle multiply
) (
  input  logic         clk,
  input  logic         reset,
  mul_arbiter_if.slave bus
);

  localparam int unsigned     WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    ABORT,
    DRAIN
  } state_t;

  state_t          state;
  logic            rr;        // requester favoured on contention
  logic            owner;     // requester of the operation in flight
  logic [WD_W-1:0] watchdog;  // cycles since acceptance
  logic            abort_q;   // one-cycle multiplier reset during ABORT
  logic            win;

  logic [1:0]  req_ack_q;
  logic        resp_valid_q;
  logic        resp_id_q;
  logic [31:0] resp_product_q;
  logic        resp_err_q;
  logic        mul_ready_q;
  logic [15:0] mul_a_q;
  logic [15:0] mul_b_q;

  // Winner selection: a lone requester wins, contention goes to rr.
  always_comb begin
    // NOTE: default first so every path assigns win and no latch is inferred.
    win = 1'b0;
    if (bus.req_valid == 2'b11) win = rr;
    else                        win = bus.req_valid[1];
  end

  // Sequencer: accept, issue, abort on watchdog, drain, with registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // sees pre-edge values, independent of statement order.
    if (reset) begin
      // NOTE: operand registers are reset too because they drive the
      // multiplier pins directly; an op in flight is simply discarded.
      state          <= IDLE;
      rr             <= 1'b0;
      owner          <= 1'b0;
      watchdog       <= '0;
      abort_q        <= 1'b0;
      req_ack_q      <= 2'b00;
      resp_valid_q   <= 1'b0;
      resp_id_q      <= 1'b0;
      resp_product_q <= '0;
      resp_err_q     <= 1'b0;
      mul_ready_q    <= 1'b0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
    end else begin
      req_ack_q    <= 2'b00;
      resp_valid_q <= 1'b0;
      abort_q      <= 1'b0;

      case (state)
        IDLE: begin
          watchdog <= '0;
          if (|bus.req_valid) begin
            req_ack_q   <= win ? 2'b10 : 2'b01;
            mul_a_q     <= win ? bus.req_a1 : bus.req_a0;
            mul_b_q     <= win ? bus.req_b1 : bus.req_b0;
            owner       <= win;
            mul_ready_q <= 1'b1;
            watchdog    <= WD_W'(1);
            state       <= ISSUE;
          end
        end

        ISSUE: begin
          if (bus.mul_done) begin
            resp_product_q <= bus.mul_product;
            resp_valid_q   <= 1'b1;
            resp_id_q      <= owner;
            resp_err_q     <= 1'b0;
            rr             <= ~owner;
            mul_ready_q    <= 1'b0;
            state          <= DRAIN;
          end else if (watchdog == WD_LIMIT) begin
            mul_ready_q <= 1'b0;
            abort_q     <= 1'b1;
            state       <= ABORT;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end

        ABORT: begin
          resp_product_q <= '0;
          resp_valid_q   <= 1'b1;
          resp_id_q      <= owner;
          resp_err_q     <= 1'b1;
          rr             <= ~owner;
          state          <= DRAIN;
        end

        DRAIN: begin
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ack      = req_ack_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_id      = resp_id_q;
  assign bus.resp_product = resp_product_q;
  assign bus.resp_err     = resp_err_q;
  assign bus.busy         = (state != IDLE);
  assign bus.mul_ready    = mul_ready_q;
  assign bus.mul_a        = mul_a_q;
  assign bus.mul_b        = mul_b_q;
  assign bus.mul_reset    = reset | abort_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: an 18-cycle multiplier model (optionally hung), a
// transaction-level reference model of the arbiter checked every cycle, and
// directed scenarios with literal expectations followed by random traffic.
module tb_mul_arbiter;

  localparam int TIMEOUT = 40;
  localparam int MUL_LAT = 18;  // mul_ready cycles until mul_done

  logic clk = 1'b0;
  logic reset;
  logic hang;
  int   cyc = 0;
  int   mcnt = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  mul_arbiter_if bus ();

  mul_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] smul(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  // Multiplier model: done in the 18th consecutive ready cycle unless hung.
  always @(posedge clk) begin
    if (bus.mul_reset || !bus.mul_ready) mcnt <= 0;
    else if (mcnt < MUL_LAT - 1)         mcnt <= mcnt + 1;
  end
  assign bus.mul_done    = bus.mul_ready && !hang && (mcnt == MUL_LAT - 1);
  assign bus.mul_product = smul(bus.mul_a, bus.mul_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: at most one operation in flight, described by the
  // cycles at which each visible event must happen.
  bit          model_on = 1'b0;
  int          free_cyc = 0;
  int          acc_cyc = -1;
  int          ack_cyc = -1;
  int          ready_end = -1;
  int          abort_cyc = -1;
  int          resp_cyc = -1;
  logic        m_rr = 1'b0;
  logic        m_id = 1'b0;
  logic        m_err = 1'b0;
  logic [15:0] m_a = '0;
  logic [15:0] m_b = '0;
  logic [31:0] m_res = '0;
  logic [31:0] m_prod = '0;

  initial begin
    logic w;
    forever begin
      @(negedge clk);
      if (model_on) begin
        if (cyc == resp_cyc) m_prod = m_res;
        check("req_ack", bus.req_ack, (cyc == ack_cyc) ? (m_id ? 2'b10 : 2'b01) : 2'b00);
        check("resp_valid", bus.resp_valid, cyc == resp_cyc);
        if (cyc == resp_cyc) begin
          check("resp_id", bus.resp_id, m_id);
          check("resp_err", bus.resp_err, m_err);
        end
        check("resp_product", bus.resp_product, m_prod);
        check("busy", bus.busy, (cyc > acc_cyc) && (cyc <= resp_cyc));
        check("mul_ready", bus.mul_ready, (cyc > acc_cyc) && (cyc <= ready_end));
        if ((cyc > acc_cyc) && (cyc <= ready_end)) begin
          check("mul_a", bus.mul_a, m_a);
          check("mul_b", bus.mul_b, m_b);
        end
        check("mul_reset", bus.mul_reset, reset || (cyc == abort_cyc));
      end
      // Advance with this cycle's inputs, which the DUT samples at the next edge.
      if (reset) begin
        model_on  = 1'b1;
        free_cyc  = cyc + 1;
        acc_cyc   = -1;
        ack_cyc   = -1;
        ready_end = -1;
        abort_cyc = -1;
        resp_cyc  = -1;
        m_rr      = 1'b0;
        m_prod    = '0;
      end else if (model_on && cyc >= free_cyc && |bus.req_valid) begin
        w       = (bus.req_valid == 2'b11) ? m_rr : bus.req_valid[1];
        m_id    = w;
        m_rr    = ~w;
        m_a     = w ? bus.req_a1 : bus.req_a0;
        m_b     = w ? bus.req_b1 : bus.req_b0;
        m_err   = hang;
        acc_cyc = cyc;
        ack_cyc = cyc + 1;
        if (hang) begin
          ready_end = cyc + TIMEOUT - 1;
          abort_cyc = cyc + TIMEOUT;
          resp_cyc  = cyc + TIMEOUT + 1;
          m_res     = '0;
        end else begin
          ready_end = cyc + MUL_LAT;
          abort_cyc = -1;
          resp_cyc  = cyc + MUL_LAT + 1;
          m_res     = smul(m_a, m_b);
        end
        free_cyc = resp_cyc + 1;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Returns at the negedge of cycle n (n must not have reached its negedge yet).
  task automatic wait_cyc(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  task automatic scramble();
    bus.req_a0 = 16'($urandom);
    bus.req_b0 = 16'($urandom);
    bus.req_a1 = 16'($urandom);
    bus.req_b1 = 16'($urandom);
  endtask

  // Single-cycle request from one requester while the arbiter is idle.
  task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b, output int t);
    next_cycle();
    t = cyc;
    scramble();
    if (id == 1) begin
      bus.req_valid = 2'b10;
      bus.req_a1    = a;
      bus.req_b1    = b;
    end else begin
      bus.req_valid = 2'b01;
      bus.req_a0    = a;
      bus.req_b0    = b;
    end
    next_cycle();
    bus.req_valid = 2'b00;
    scramble();
  endtask

  initial begin
    int t;
    reset         = 1'b1;
    hang          = 1'b0;
    bus.req_valid = 2'b00;
    scramble();
    repeat (3) next_cycle();
    reset = 1'b0;
    wait_cyc(cyc);
    check("rst_resp_id", bus.resp_id, 1'b0);
    check("rst_resp_err", bus.resp_err, 1'b0);
    check("rst_mul_a", bus.mul_a, 16'h0000);
    check("rst_mul_b", bus.mul_b, 16'h0000);

    // Lone requester 0: ack T+1, done T+18, response T+19.
    issue(0, 16'd3, 16'd5, t);
    wait_cyc(t + 1);
    check("t1_ack", bus.req_ack, 2'b01);
    wait_cyc(t + 18);
    check("t1_done", bus.mul_done, 1'b1);
    wait_cyc(t + 19);
    check("t1_resp_valid", bus.resp_valid, 1'b1);
    check("t1_resp_id", bus.resp_id, 1'b0);
    check("t1_product", bus.resp_product, 32'd15);

    // Reset 10 cycles into an op: no response, idle, rr back to requester 0.
    wait_cyc(t + 21);
    issue(0, 16'd7, 16'd7, t);
    wait_cyc(t + 9);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    wait_cyc(t + 11);
    check("t5_busy", bus.busy, 1'b0);
    check("t5_mul_reset", bus.mul_reset, 1'b1);
    next_cycle();
    reset         = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_a0    = 16'd4;
    bus.req_b0    = 16'd5;
    bus.req_a1    = 16'd6;
    bus.req_b1    = 16'd7;
    next_cycle();
    bus.req_valid = 2'b00;
    wait_cyc(t + 13);
    check("t5_ack", bus.req_ack, 2'b01);
    wait_cyc(t + 31);
    check("t5_resp_valid", bus.resp_valid, 1'b1);
    check("t5_product", bus.resp_product, 32'd20);
    wait_cyc(t + 33);

    // Lone requester 1 with a negative operand.
    issue(1, 16'hFFF9, 16'd9, t);
    wait_cyc(t + 19);
    check("t2_product", bus.resp_product, 32'hFFFFFFC1);
    check("t2_resp_id", bus.resp_id, 1'b1);
    check("t2_resp_err", bus.resp_err, 1'b0);

    // Extreme operands.
    wait_cyc(t + 21);
    issue(0, 16'h8000, 16'h8000, t);
    wait_cyc(t + 19);
    check("t6_min_min", bus.resp_product, 32'h40000000);
    wait_cyc(t + 21);
    issue(1, 16'h8000, 16'h0001, t);
    wait_cyc(t + 19);
    check("t6_min_one", bus.resp_product, 32'hFFFF8000);

    // Hung multiplier: watchdog abort, then a normal op.
    wait_cyc(t + 21);
    hang = 1'b1;
    issue(0, 16'd2, 16'd3, t);
    wait_cyc(t + TIMEOUT - 1);
    check("t4_reset_before", bus.mul_reset, 1'b0);
    wait_cyc(t + TIMEOUT);
    check("t4_mul_reset", bus.mul_reset, 1'b1);
    wait_cyc(t + TIMEOUT + 1);
    check("t4_resp_valid", bus.resp_valid, 1'b1);
    check("t4_resp_err", bus.resp_err, 1'b1);
    check("t4_product", bus.resp_product, 32'h0);
    check("t4_reset_after", bus.mul_reset, 1'b0);
    wait_cyc(t + TIMEOUT + 2);
    hang = 1'b0;
    issue(1, 16'd100, 16'hFFFE, t);
    wait_cyc(t + 19);
    check("t4_recover_product", bus.resp_product, 32'hFFFFFF38);
    check("t4_recover_err", bus.resp_err, 1'b0);

    // Both requesting continuously from reset: grants alternate 0,1,0,1.
    wait_cyc(t + 21);
    next_cycle();
    reset         = 1'b1;
    bus.req_valid = 2'b11;
    bus.req_a0    = 16'd10;
    bus.req_b0    = 16'd11;
    bus.req_a1    = 16'hFFFD;
    bus.req_b1    = 16'd12;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    t     = cyc;
    for (int k = 0; k < 4; k++) begin
      wait_cyc(t + 20 * k + 1);
      check("t3_ack", bus.req_ack, (k % 2 == 1) ? 2'b10 : 2'b01);
      if (k == 3) begin
        next_cycle();
        bus.req_valid = 2'b00;
      end
      wait_cyc(t + 20 * k + 19);
      check("t3_resp_id", bus.resp_id, k % 2);
      check("t3_product", bus.resp_product, (k % 2 == 1) ? 32'hFFFFFFDC : 32'd110);
    end

    // Random traffic with occasional resets, then with a hung multiplier.
    repeat (3) next_cycle();
    for (int i = 0; i < 1500; i++) begin
      next_cycle();
      bus.req_valid = 2'($urandom_range(0, 3));
      scramble();
      reset = ($urandom_range(0, 199) == 0);
    end
    next_cycle();
    reset         = 1'b0;
    bus.req_valid = 2'b00;
    repeat (60) next_cycle();
    hang = 1'b1;
    for (int i = 0; i < 400; i++) begin
      next_cycle();
      bus.req_valid = 2'($urandom_range(0, 3));
      scramble();
      reset = ($urandom_range(0, 149) == 0);
    end
    next_cycle();
    reset         = 1'b0;
    bus.req_valid = 2'b00;
    repeat (60) next_cycle();
    hang = 1'b0;
    repeat (3) next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
